picobus_port_router: RTL and testbench
======================================

// Module: picobus_port_router
// PURPOSE
//  Parametrised I/O fabric between the KCPSM6 core and NUM_CH peripherals (RTC, VGA, keyboard, sound, ...).
//  Decodes port_id into per-channel address windows and registers write/read strobes, write data and offset.
//  Multiplexes the peripherals' read data back onto in_port.
//  Aggregates per-channel interrupt requests into the single CPU interrupt, with a pending/enable/ack controller.
// PARAMETERS
//  NUM_CH      4      peripheral channel count, 1..8
//  CH_BITS     4      offset bits per window; channel k occupies BASE + (k << CH_BITS)
//  BASE        8'h00  base port of channel 0, aligned to 2**CH_BITS
//  KCH         0      channel that receives OUTPUTK (k_write_strobe) writes
//  IRQ_STAT    8'hF0  read port: {valid, 4'b0, src[2:0]}; a read also acknowledges service
//  IRQ_EN      8'hF1  read/write port: interrupt enable mask, bits [NUM_CH-1:0]
// PORTS
//  clk            in   1              system clock
//  kcpsm6_reset   in   1              asynchronous, active-high reset
//  port_id        in   8              CPU port address
//  out_port       in   8              CPU write data
//  write_strobe   in   1              OUTPUT strobe
//  k_write_strobe in   1              OUTPUTK strobe (only port_id[3:0] valid)
//  read_strobe    in   1              INPUT strobe
//  in_port        out  8              registered read data to CPU
//  interrupt      out  1              interrupt request to CPU
//  interrupt_ack  in   1              CPU interrupt acknowledge pulse
//  ch_wr          out  NUM_CH         one-cycle write pulse per channel
//  ch_rd          out  NUM_CH         one-cycle read pulse per channel (FIFO pop)
//  ch_dir         out  CH_BITS        registered offset within the addressed window
//  ch_wdata       out  8              registered write data
//  ch_rdata       in   8*NUM_CH       per-channel read data; channel k at [8k+7:8k]
//  ch_irq         in   NUM_CH         level interrupt requests; rising edge latches pending
// BEHAVIOUR
//  Decode: hit[k] = (port_id[7:CH_BITS] == BASE[7:CH_BITS] + k). IRQ_STAT/IRQ_EN take priority over any window.
//  Write: write_strobe & hit[k] -> next cycle ch_wr[k]=1 for exactly 1 cycle.
//    In the same cycle ch_wdata=out_port and ch_dir=port_id[CH_BITS-1:0]; these hold until the next write.
//  OUTPUTK: k_write_strobe -> ch_wr[KCH] next cycle, ch_dir=port_id[3:0] zero-extended/truncated. No window decode.
//  Write to IRQ_EN -> en <= out_port[NUM_CH-1:0] next cycle; no ch_wr pulse.
//  Read: in_port is registered every cycle from port_id (1-cycle latency, within KCPSM6's 2-cycle window):
//    hit[k] -> ch_rdata[k]; IRQ_STAT -> status; IRQ_EN -> en; unmapped -> 8'h00.
//  read_strobe & hit[k] -> ch_rd[k]=1 for 1 cycle, next cycle.
//  IRQ capture: irq_q <= ch_irq; pending[k] set on ch_irq[k] & ~irq_q[k].
//    Set beats clear when both occur in the same cycle.
//  IRQ FSM (registered interrupt output):
//    IDLE:    if |(pending & en) -> ASSERT (interrupt=1 next cycle)
//    ASSERT:  interrupt=1.
//             On interrupt_ack: src <= lowest k with pending&en; clear pending[src]; valid<=1; -> SERVICE, interrupt=0.
//             If pending&en becomes 0 (mask write) before ack -> IDLE, interrupt=0.
//    SERVICE: interrupt=0. New edges only set pending. read_strobe at IRQ_STAT -> valid<=0, -> IDLE.
//  Reset (async, any time, including mid-transfer):
//    in_port=0, interrupt=0, ch_wr=0, ch_rd=0, ch_dir=0, ch_wdata=0;
//    pending=0, en=0, irq_q=0, src=0, valid=0, FSM=IDLE.
//  Strobes on two channels cannot coexist: the CPU issues one strobe per instruction.
// STRUCTURE
//  picobus_defs.vh: IRQ FSM state localparams (IDLE=2'd0, ASSERT=2'd1, SERVICE=2'd2), default port constants.
//  Sub-module picobus_irq_ctrl: edge capture, pending/en registers, priority encoder, FSM.
//  Top level: decode, strobe/data registers, in_port mux.
// TESTING
//  1. OUTPUT 8'h12 -> port 8'h13 -> ch_wr=4'b0010 one cycle later for 1 cycle; ch_wdata=8'h12; ch_dir=4'h3.
//  2. OUTPUTK 8'hA5, port_id[3:0]=4'h7, KCH=0 -> ch_wr[0] pulse; ch_dir=4'h7; ch_wdata=8'hA5.
//  3. ch_rdata[2]=8'h5C, port_id=8'h20 -> in_port=8'h5C after 1 cycle and ch_rd[2] pulse.
//     port_id=8'h80 -> in_port=8'h00.
//  4. en=4'b1111, rising edges on ch_irq[3] and ch_irq[1] in the same cycle -> interrupt=1;
//     ack -> src=1, interrupt=0; read F0 -> 8'h81, IDLE; interrupt reasserts for src=3.
//  5. en=0, edge on ch_irq[0] -> no interrupt; write F1=8'h01 -> interrupt=1 within 2 cycles;
//     write F1=8'h00 before ack -> interrupt=0, FSM IDLE.
//  6. Assert kcpsm6_reset during ASSERT with pending bits -> all outputs 0 immediately, pending=0, en=0.

Source files
------------

// File: rtl/picobus_port_router_pkg.sv
// Shared types and constants for the KCPSM6 port router and its interrupt controller.
package picobus_port_router_pkg;

  typedef enum logic [1:0] {
    IrqIdle    = 2'd0,
    IrqAssert  = 2'd1,
    IrqService = 2'd2
  } irq_state_e;

  localparam logic [7:0] DefBase    = 8'h00;
  localparam logic [7:0] DefIrqStat = 8'hF0;
  localparam logic [7:0] DefIrqEn   = 8'hF1;

  function automatic logic [7:0] status_byte(input logic valid, input logic [2:0] src);
    return {valid, 4'b0000, src};
  endfunction

endpackage

// File: rtl/picobus_port_router_irq_ctrl.sv
// Interrupt aggregation: edge capture, pending/enable registers, lowest-index priority and
// the IDLE/ASSERT/SERVICE handshake with the CPU.
module picobus_port_router_irq_ctrl
  import picobus_port_router_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_irq,
  input  logic              en_we,
  input  logic [NUM_CH-1:0] en_wdata,
  input  logic              stat_rd,
  input  logic              interrupt_ack,
  output logic              interrupt,
  output logic [NUM_CH-1:0] en,
  output logic [7:0]        status
);

  irq_state_e        state_q;
  logic [NUM_CH-1:0] irq_q;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] lowest_mask;
  logic [NUM_CH-1:0] clr_mask;
  logic [2:0]        lowest;
  logic [2:0]        src_q;
  logic              valid_q;
  logic              any_active;
  logic              take;

  assign active     = pending_q & en;
  assign any_active = |active;
  assign take       = (state_q == IrqAssert) && interrupt_ack && any_active;
  assign clr_mask   = take ? lowest_mask : '0;
  assign status     = status_byte(valid_q, src_q);

  // Scan downward so the lowest active index wins.
  always_comb begin
    lowest      = '0;
    lowest_mask = '0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (active[k]) begin
        lowest      = 3'(k);
        lowest_mask = '0;
        lowest_mask[k] = 1'b1;
      end
    end
  end

  // A fresh edge in the same cycle as the ack-clear keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q     <= '0;
      pending_q <= '0;
      en        <= '0;
    end else begin
      irq_q     <= ch_irq;
      pending_q <= (pending_q & ~clr_mask) | (ch_irq & ~irq_q);
      if (en_we) en <= en_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IrqIdle;
      interrupt <= 1'b0;
      src_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IrqIdle: begin
          if (any_active) begin
            state_q   <= IrqAssert;
            interrupt <= 1'b1;
          end
        end
        IrqAssert: begin
          if (!any_active) begin
            state_q   <= IrqIdle;
            interrupt <= 1'b0;
          end else if (interrupt_ack) begin
            src_q     <= lowest;
            valid_q   <= 1'b1;
            state_q   <= IrqService;
            interrupt <= 1'b0;
          end
        end
        IrqService: begin
          if (stat_rd) begin
            valid_q <= 1'b0;
            state_q <= IrqIdle;
          end
        end
        default: begin
          state_q   <= IrqIdle;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/picobus_port_router.sv
// KCPSM6 I/O fabric: window decode, registered write/read strobes and data, read-back mux,
// and the aggregated CPU interrupt.
module picobus_port_router
  import picobus_port_router_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_BITS  = 4,
  parameter logic [7:0]  BASE     = DefBase,
  parameter int unsigned KCH      = 0,
  parameter logic [7:0]  IRQ_STAT = DefIrqStat,
  parameter logic [7:0]  IRQ_EN   = DefIrqEn
) (
  input  logic                clk,
  input  logic                kcpsm6_reset,
  input  logic [7:0]          port_id,
  input  logic [7:0]          out_port,
  input  logic                write_strobe,
  input  logic                k_write_strobe,
  input  logic                read_strobe,
  output logic [7:0]          in_port,
  output logic                interrupt,
  input  logic                interrupt_ack,
  output logic [NUM_CH-1:0]   ch_wr,
  output logic [NUM_CH-1:0]   ch_rd,
  output logic [CH_BITS-1:0]  ch_dir,
  output logic [7:0]          ch_wdata,
  input  logic [8*NUM_CH-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]   ch_irq
);

  logic [NUM_CH-1:0]  hit;
  logic [NUM_CH-1:0]  wr_d;
  logic [NUM_CH-1:0]  en;
  logic [CH_BITS-1:0] k_dir;
  logic [7:0]         status;
  logic [7:0]         rd_d;
  logic               is_stat;
  logic               is_en;

  assign is_stat = (port_id == IRQ_STAT);
  assign is_en   = (port_id == IRQ_EN);

  // The IRQ ports shadow any window that happens to cover them.
  always_comb begin
    hit = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      hit[k] = ((port_id >> CH_BITS) == ((BASE >> CH_BITS) + 8'(k))) && !is_stat && !is_en;
    end
  end

  // OUTPUTK only carries a 4-bit port address.
  always_comb begin
    k_dir = '0;
    for (int i = 0; i < int'(CH_BITS); i++) begin
      if (i < 4) k_dir[i] = port_id[i];
    end
  end

  always_comb begin
    wr_d = write_strobe ? hit : '0;
    if (k_write_strobe) wr_d[KCH] = 1'b1;
  end

  always_comb begin
    rd_d = '0;
    if (is_stat) begin
      rd_d = status;
    end else if (is_en) begin
      rd_d[NUM_CH-1:0] = en;
    end else begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        if (hit[k]) rd_d = ch_rdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge kcpsm6_reset) begin
    if (kcpsm6_reset) begin
      ch_wr    <= '0;
      ch_rd    <= '0;
      ch_dir   <= '0;
      ch_wdata <= '0;
      in_port  <= '0;
    end else begin
      ch_wr   <= wr_d;
      ch_rd   <= read_strobe ? hit : '0;
      in_port <= rd_d;
      if (write_strobe && |hit) begin
        ch_wdata <= out_port;
        ch_dir   <= port_id[CH_BITS-1:0];
      end else if (k_write_strobe) begin
        ch_wdata <= out_port;
        ch_dir   <= k_dir;
      end
    end
  end

  picobus_port_router_irq_ctrl #(
    .NUM_CH(NUM_CH)
  ) u_irq_ctrl (
    .clk          (clk),
    .rst          (kcpsm6_reset),
    .ch_irq       (ch_irq),
    .en_we        (write_strobe && is_en),
    .en_wdata     (out_port[NUM_CH-1:0]),
    .stat_rd      (read_strobe && is_stat),
    .interrupt_ack(interrupt_ack),
    .interrupt    (interrupt),
    .en           (en),
    .status       (status)
  );

endmodule

// File: tb/tb_picobus_port_router.sv
// Directed bench for picobus_port_router with a queue of expected values.
module tb_picobus_port_router;

  logic        clk = 1'b0;
  logic        kcpsm6_reset = 1'b0;
  logic [7:0]  port_id = '0;
  logic [7:0]  out_port = '0;
  logic        write_strobe = 1'b0;
  logic        k_write_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack = 1'b0;
  logic [3:0]  ch_wr;
  logic [3:0]  ch_rd;
  logic [3:0]  ch_dir;
  logic [7:0]  ch_wdata;
  logic [31:0] ch_rdata = '0;
  logic [3:0]  ch_irq = '0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  picobus_port_router dut (
    .clk           (clk),
    .kcpsm6_reset  (kcpsm6_reset),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .k_write_strobe(k_write_strobe),
    .read_strobe   (read_strobe),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .ch_wr         (ch_wr),
    .ch_rd         (ch_rd),
    .ch_dir        (ch_dir),
    .ch_wdata      (ch_wdata),
    .ch_rdata      (ch_rdata),
    .ch_irq        (ch_irq)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, observed before any clock edge
    #2 kcpsm6_reset = 1'b1;
    push("rst_in_port", 0);  push("rst_interrupt", 0); push("rst_ch_wr", 0);
    push("rst_ch_rd", 0);    push("rst_ch_dir", 0);    push("rst_ch_wdata", 0);
    #1;
    pop_check(in_port); pop_check(interrupt); pop_check(ch_wr);
    pop_check(ch_rd);   pop_check(ch_dir);    pop_check(ch_wdata);
    repeat (2) step();
    kcpsm6_reset = 1'b0;
    step();

    // OUTPUT 0x12 to port 0x13
    port_id = 8'h13; out_port = 8'h12; write_strobe = 1'b1;
    push("t1_wr_pulse", 4'b0010); push("t1_wdata", 8'h12); push("t1_dir", 4'h3);
    step();
    write_strobe = 1'b0;
    pop_check(ch_wr); pop_check(ch_wdata); pop_check(ch_dir);
    push("t1_wr_end", 4'b0000); push("t1_wdata_hold", 8'h12);
    step();
    pop_check(ch_wr); pop_check(ch_wdata);

    // OUTPUTK 0xA5 with port_id[3:0]=7; upper bits would otherwise decode to channel 2
    port_id = 8'h27; out_port = 8'hA5; k_write_strobe = 1'b1;
    push("t2_kwr_pulse", 4'b0001); push("t2_kdir", 4'h7); push("t2_kwdata", 8'hA5);
    step();
    k_write_strobe = 1'b0;
    pop_check(ch_wr); pop_check(ch_dir); pop_check(ch_wdata);
    push("t2_kwr_end", 4'b0000);
    step();
    pop_check(ch_wr);

    // Read channel 2, then an unmapped port
    ch_rdata = {8'h44, 8'h5C, 8'h22, 8'h11};
    port_id = 8'h20; read_strobe = 1'b1;
    push("t3_rdata", 8'h5C); push("t3_rd_pulse", 4'b0100);
    step();
    read_strobe = 1'b0;
    pop_check(in_port); pop_check(ch_rd);
    port_id = 8'h80;
    push("t3_rd_end", 4'b0000); push("t3_unmapped", 8'h00);
    step();
    pop_check(ch_rd); pop_check(in_port);

    // Enable all, simultaneous edges on channels 3 and 1
    port_id = 8'hF1; out_port = 8'h0F; write_strobe = 1'b1;
    push("t4_en_no_wr", 4'b0000);
    step();
    write_strobe = 1'b0;
    pop_check(ch_wr);
    push("t4_en_read", 8'h0F);
    step();
    pop_check(in_port);
    ch_irq = 4'b1010;
    push("t4_irq_latency", 0);
    step();
    pop_check(interrupt);
    push("t4_irq_assert", 1);
    step();
    pop_check(interrupt);
    interrupt_ack = 1'b1;
    push("t4_ack_drop", 0);
    step();
    interrupt_ack = 1'b0;
    pop_check(interrupt);
    port_id = 8'hF0; read_strobe = 1'b1;
    push("t4_status_src1", 8'h81);
    step();
    read_strobe = 1'b0;
    pop_check(in_port);
    push("t4_reassert", 1); push("t4_status_idle", 8'h01);
    step();
    pop_check(interrupt); pop_check(in_port);
    interrupt_ack = 1'b1;
    push("t4_ack2_drop", 0);
    step();
    interrupt_ack = 1'b0;
    pop_check(interrupt);
    read_strobe = 1'b1;
    push("t4_status_src3", 8'h83);
    step();
    read_strobe = 1'b0;
    pop_check(in_port);

    // Masked edge, unmask, then re-mask before ack
    ch_irq = 4'b0000;
    port_id = 8'hF1; out_port = 8'h00; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
    step();
    ch_irq = 4'b0001;
    repeat (3) step();
    push("t5_masked", 0);
    pop_check(interrupt);
    out_port = 8'h01; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
    for (int i = 0; i < 2 && interrupt !== 1'b1; i++) step();
    push("t5_unmask_irq", 1);
    pop_check(interrupt);
    out_port = 8'h00; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
    step();
    push("t5_mask_drop", 0);
    pop_check(interrupt);
    push("t5_stays_idle", 0);
    step();
    pop_check(interrupt);
    port_id = 8'hF0;
    push("t5_status_novalid", 8'h03);
    step();
    pop_check(in_port);

    // Async reset while ASSERT is active and a channel write is in flight
    port_id = 8'hF1; out_port = 8'h0F; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
    push("t6_pre_irq", 1);
    step();
    pop_check(interrupt);
    port_id = 8'h35; out_port = 8'h77; write_strobe = 1'b1;
    push("t6_pre_wr", 4'b1000);
    step();
    write_strobe = 1'b0;
    pop_check(ch_wr);
    kcpsm6_reset = 1'b1;
    ch_irq = 4'b0000;
    push("t6_rst_irq", 0);   push("t6_rst_wr", 0);    push("t6_rst_wdata", 0);
    push("t6_rst_dir", 0);   push("t6_rst_in_port", 0);
    #1;
    pop_check(interrupt); pop_check(ch_wr); pop_check(ch_wdata);
    pop_check(ch_dir);    pop_check(in_port);
    repeat (2) step();
    kcpsm6_reset = 1'b0;
    port_id = 8'hF1;
    push("t6_en_cleared", 8'h00);
    step();
    pop_check(in_port);
    port_id = 8'hF0;
    push("t6_status_cleared", 8'h00);
    step();
    pop_check(in_port);
    port_id = 8'hF1; out_port = 8'h0F; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
    repeat (3) step();
    push("t6_no_pending", 0);
    pop_check(interrupt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
